// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared constants, register offsets, STATUS bit positions and FSM encoding
package uart_tx_mmio_pkg;

   localparam logic ENABLE     = 1'b1;
   localparam logic DISABLE    = 1'b0;
   localparam int   REG_LENGTH = 32;

   // Register offsets as seen on addr[3:2]
   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;

   localparam int ST_BUSY   = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_EMPTY  = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_CNT_LO = 4;
   localparam int ST_CNT_HI = 8;
   localparam int ST_PARITY = 9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } txState_t;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - CPU data-memory bus bundle (master = core, slave = peripheral)
interface uart_tx_mmio_if;
   logic        ce;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wtData;
   logic [31:0] rdData;

   modport master (output ce, output we, output addr, output wtData, input rdData);
   modport slave  (input ce, input we, input addr, input wtData, output rdData);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous TX FIFO; a push while full is accepted only alongside a pop
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign full   = (count == DEPTH[AW:0]);
   assign empty  = (count == '0);
   assign dout   = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_mmio_if.slave   bus,
   output logic            txd,
   output logic            txIrq
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   txState_t          state, nextState;
   logic              hit, pushReq, statusWr, divWr;
   logic [1:0]        offset;
   logic [7:0]        fifoDout;
   logic              fifoFull, fifoEmpty, pop;
   logic [CW-1:0]     fifoCount;
   logic [15:0]       divReg, curDiv, divCnt;
   logic [2:0]        bitIdx;
   logic [7:0]        shReg;
   logic              overflow, bitEnd, txdNext;
   logic [REG_LENGTH-1:0] statusWord, rdWord;
`ifdef UART_TX_PARITY_EN
   logic              parBit;
`endif
   logic              unusedBits;

   assign offset     = bus.addr[3:2];
   assign hit        = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign pushReq    = hit && bus.we && (offset == OFF_TXDATA);
   assign statusWr   = hit && bus.we && (offset == OFF_STATUS);
   assign divWr      = hit && bus.we && (offset == OFF_DIV);
   assign bitEnd     = (divCnt == 16'd0);
   assign txIrq      = fifoEmpty && (state == IDLE);
   assign unusedBits = &{1'b0, bus.addr[1:0], bus.wtData[31:16]};

   uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) uFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pushReq),
      .pop   (pop),
      .din   (bus.wtData[7:0]),
      .dout  (fifoDout),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (!fifoEmpty) nextState = START;
         START: if (bitEnd) nextState = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (bitEnd && bitIdx == 3'd7) nextState = PARITY;
         PARITY: if (bitEnd) nextState = STOP;
`else
         DATA:   if (bitEnd && bitIdx == 3'd7) nextState = STOP;
`endif
         STOP:  if (bitEnd) nextState = fifoEmpty ? IDLE : START;
         default: nextState = IDLE;
      endcase
   end

   // The frame loads from the FIFO head whenever START is entered, including back-to-back from STOP
   always_comb begin
      pop     = (nextState == START) && (state == IDLE || state == STOP);
      txdNext = 1'b1;
      case (nextState)
         START:  txdNext = 1'b0;
         DATA:   txdNext = (state == DATA && bitEnd) ? shReg[1] : shReg[0];
`ifdef UART_TX_PARITY_EN
         PARITY: txdNext = parBit;
`endif
         default: txdNext = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         txd      <= 1'b1;
         divReg   <= 16'(CLK_DIV);
         curDiv   <= 16'(CLK_DIV);
         divCnt   <= 16'd0;
         bitIdx   <= 3'd0;
         shReg    <= 8'd0;
         overflow <= DISABLE;
`ifdef UART_TX_PARITY_EN
         parBit   <= 1'b0;
`endif
      end else begin
         txd <= txdNext;
         if (divWr) divReg <= (bus.wtData[15:0] < 16'd2) ? 16'd2 : bus.wtData[15:0];
         if (statusWr)                           overflow <= DISABLE;
         else if (pushReq && fifoFull && !pop)   overflow <= ENABLE;
         if (pop) begin
            // Divisor is frozen per frame so a mid-frame DIV write only affects later frames
            shReg  <= fifoDout;
            curDiv <= divReg;
            divCnt <= divReg - 16'd1;
            bitIdx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parBit <= ^fifoDout;
`endif
         end else if (bitEnd && state != IDLE) begin
            divCnt <= curDiv - 16'd1;
            if (state == DATA) begin
               shReg  <= shReg >> 1;
               bitIdx <= bitIdx + 3'd1;
            end
         end else if (!bitEnd) begin
            divCnt <= divCnt - 16'd1;
         end
      end
   end

   always_comb begin
      statusWord                      = '0;
      statusWord[ST_BUSY]             = (state != IDLE);
      statusWord[ST_FULL]             = fifoFull;
      statusWord[ST_EMPTY]            = fifoEmpty;
      statusWord[ST_OVF]              = overflow;
      statusWord[ST_CNT_HI:ST_CNT_LO] = 5'(fifoCount);
`ifdef UART_TX_PARITY_EN
      statusWord[ST_PARITY]           = 1'b1;
`endif
   end

   always_comb begin
      rdWord = '0;
      if (hit && !bus.we) begin
         case (offset)
            OFF_STATUS: rdWord = statusWord;
            OFF_DIV:    rdWord = {16'd0, divReg};
            default:    rdWord = '0;
         endcase
      end
   end

   assign bus.rdData = rdWord;
endmodule
